// File: rtl/sum_seq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package sum_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sum_seq_state_t;

    localparam int unsigned NIB_W = 4;

endpackage

// File: rtl/add4_cin.sv
// Combinational 4-bit ripple adder with live carry-in, built from full-adder cells.
module add4_cin
    import sum_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             co
);

    logic [NIB_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < NIB_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[NIB_W];

endmodule

// File: rtl/sum_seq_ctrl.sv
// Nibble-serial add/subtract sequencer: one shared 4-bit adder slice walks the
// operands LSB nibble first, carrying between nibbles through a register.
module sum_seq_ctrl
    import sum_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    sum_seq_state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic             carry_q, cout_q, ovf_q;
    logic [IDX_W-1:0] idx_q;

    logic [NIB_W-1:0] slice_a, slice_b, slice_s;
    logic             slice_co;
    logic             accept, last;

    assign accept = (state_q == IDLE) && start;
    assign last   = (state_q == RUN) && (idx_q == LAST_IDX);

    assign slice_a = a_q[idx_q*NIB_W +: NIB_W];
    assign slice_b = b_q[idx_q*NIB_W +: NIB_W];

    add4_cin u_add4 (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Subtraction is A + ~B + 1: invert B at latch time and seed the carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= op_sub ? ~b : b;
            carry_q <= op_sub;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == RUN) begin
            sum_q[idx_q*NIB_W +: NIB_W] <= slice_s;
            carry_q                     <= slice_co;
            if (idx_q == LAST_IDX) begin
                cout_q <= slice_co;
                ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[NIB_W-1] != a_q[WIDTH-1]);
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Self-checking bench for sum_seq_ctrl (WIDTH=16) against an arithmetic reference model.
module tb_sum_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op_sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, cout, ovf;
    logic [15:0] sum;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sum_seq_ctrl #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; overflow is "true signed result out of range".
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic msub,
                                  output logic [15:0] s, output logic c, output logic v);
        int unsigned ua = 32'(ma);
        int unsigned ub = 32'(mb);
        int sa = int'($signed(ma));
        int sb = int'($signed(mb));
        int r;
        if (!msub) begin
            s = 16'(ua + ub);
            c = ((ua + ub) > 32'd65535);
            r = sa + sb;
        end else begin
            s = 16'(ua - ub);
            c = (ua >= ub);
            r = sa - sb;
        end
        v = (r > 32767) || (r < -32768);
    endfunction

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_sum"},  32'(sum),  0);
        check({tag, "_cout"}, 32'(cout), 0);
        check({tag, "_ovf"},  32'(ovf),  0);
    endtask

    // One operation; noise pulses start with junk operands during RUN and DONE.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tsub,
                          input bit noise, input string tag);
        logic [15:0] es;
        logic ec, ev;
        int edges = 0;
        int busy_cnt = 0;
        bit seen = 0;
        model(ta, tb, tsub, es, ec, ev);
        @(negedge clk);
        a = ta; b = tb; op_sub = tsub; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); op_sub = 1'($urandom);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) check({tag, "_sum_cleared"}, 32'(sum), 0);
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1;
                break;
            end
            start = noise && (edges == 1);
            if (start) begin
                a = 16'($urandom); b = 16'($urandom); op_sub = 1'($urandom);
            end
            @(posedge clk);
            edges++;
        end
        if (!seen) begin
            check({tag, "_done_timeout"}, 0, 1);
        end else begin
            check({tag, "_latency"}, 32'(edges), 4);
            check({tag, "_busy_cycles"}, 32'(busy_cnt), 5);
            check({tag, "_sum"}, 32'(sum), 32'(es));
            check({tag, "_cout"}, 32'(cout), 32'(ec));
            check({tag, "_ovf"}, 32'(ovf), 32'(ev));
        end
        if (noise) begin
            start = 1'b1;
            a = 16'($urandom); b = 16'($urandom); op_sub = 1'($urandom);
        end
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy), 0);
        check({tag, "_idle_done"}, 32'(done), 0);
        check({tag, "_hold_sum"}, 32'(sum), 32'(es));
        check({tag, "_hold_cout"}, 32'(cout), 32'(ec));
    endtask

    initial begin
        logic [15:0] es;
        logic ec, ev;
        int done_at[$];
        int done_in_reset;
        bit went_idle;

        #12;
        check_idle_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_op(16'h1234, 16'h0FFF, 1'b0, 0, "add_1234_0fff");
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, "add_ffff_0001");
        run_op(16'h8000, 16'h0001, 1'b1, 0, "sub_8000_0001");
        run_op(16'h0003, 16'h0005, 1'b1, 0, "sub_0003_0005");
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, "add_7fff_0001");
        run_op(16'h5A5A, 16'h1111, 1'b0, 1, "noise_add");
        run_op(16'h1000, 16'h2000, 1'b1, 1, "noise_sub");

        for (int i = 0; i < 24; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand");
        end

        // Level-held start: back-to-back operations.
        model(16'hABCD, 16'h1357, 1'b1, es, ec, ev);
        @(negedge clk);
        a = 16'hABCD; b = 16'h1357; op_sub = 1'b1; start = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                done_at.push_back(k);
                check("b2b_sum", 32'(sum), 32'(es));
                check("b2b_ovf", 32'(ovf), 32'(ev));
            end
        end
        start = 1'b0;
        if (done_at.size() < 2) begin
            check("b2b_done_count", 32'(done_at.size()), 2);
        end else begin
            check("b2b_period", 32'(done_at[1] - done_at[0]), 6);
        end
        went_idle = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!busy) begin
                went_idle = 1;
                break;
            end
        end
        check("b2b_return_idle", 32'(went_idle), 1);

        // Reset in the second RUN cycle aborts with no done.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_zero("abort");
        done_in_reset = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) done_in_reset++;
        end
        check("abort_no_done", 32'(done_in_reset), 0);
        rst_n = 1'b1;
        run_op(16'h1111, 16'h2222, 1'b0, 0, "after_abort");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=1 expected=0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sum_seq_ctrl.md
# sum_seq_ctrl

Nibble-serial add/subtract sequencer. It drives one 4-bit ripple adder slice with carry-in over successive cycles to produce a WIDTH-bit sum or difference, with a registered inter-nibble carry. It sits between a requester issuing start/operand pulses and the shared 4-bit adder datapath. It trades latency (WIDTH/4 cycles) for a single 4-bit adder instance.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 8; NIB = WIDTH/4.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, reset; asynchronous, active-low.
- start, input, 1, request; sampled only in IDLE.
- op_sub, input, 1, 0 = A+B, 1 = A−B; sampled with start.
- a, input, WIDTH, operand A; sampled with start.
- b, input, WIDTH, operand B; sampled with start.
- busy, output, 1, high whenever state ≠ IDLE.
- done, output, 1, one-cycle pulse; result valid.
- sum, output, WIDTH, result register.
- cout, output, 1, final carry out; for subtract, 1 = no borrow.
- ovf, output, 1, two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1 at a clock edge:
  - latch a_r ← a and b_r ← (op_sub ? ~b : b);
  - carry_r ← op_sub; idx ← 0; sum ← 0; cout ← 0; ovf ← 0;
  - go to RUN.
- IDLE, start=0: hold state; sum/cout/ovf keep the last result.
- RUN, each edge:
  - the add4 slice computes a_r[4·idx+:4] + b_r[4·idx+:4] + carry_r;
  - sum[4·idx+:4] ← slice sum; carry_r ← slice carry; idx ← idx+1.
- RUN, edge with idx = NIB−1:
  - additionally cout ← slice carry;
  - ovf ← (a_r[WIDTH−1] == b_r[WIDTH−1]) && (slice sum[3] ≠ a_r[WIDTH−1]);
  - go to DONE.
- DONE: done = 1 for exactly this cycle; next edge returns to IDLE unconditionally.
- Width rules:
  - idx is $clog2(NIB) bits and never wraps during RUN.
  - The result is modulo 2^WIDTH; the carry beyond the MSB is reported only on cout.
- start asserted in RUN or DONE is ignored; no queuing. A level-held start is re-accepted in the IDLE cycle after DONE.
- Operands and op_sub may change freely after acceptance; only the latched copies are used.
- Partial results are visible on sum during RUN. They are not valid until done.

## Timing
- Reset values, asserted asynchronously: state = IDLE; busy, done, cout, ovf = 0; sum = 0; carry_r = 0; idx = 0.
- Reset mid-RUN or mid-DONE:
  - immediate abort; all outputs return to reset values;
  - no done pulse is emitted.
- Reset release: the first edge with rst_n=1 may accept start.
- Latency, with start accepted at edge E:
  - busy rises after E;
  - nibbles are processed on edges E+1 … E+NIB;
  - done is high in the cycle after edge E+NIB.
  - For WIDTH=16, that is 4 edges after acceptance.
- Throughput: one operation per NIB+2 cycles (accept, NIB RUN edges, DONE).
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Package sum_seq_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} sum_seq_state_t;
  - localparam NIB_W = 4.
- Sub-module add4_cin: purely combinational 4-bit ripple adder.
  - Ports a[3:0], b[3:0], ci, s[3:0], co.
  - Built from 1-bit full adders; carry-in is live (not tied to 0).
  - Instantiated once.
- Top level: FSM, operand/carry/index registers, nibble mux and demux.

## Test plan
- Add 0x1234 + 0x0FFF (WIDTH=16) → sum 0x2233, cout 0, ovf 0; done exactly 4 edges after accept; busy high for 5 cycles.
- Add 0xFFFF + 0x0001 → sum 0x0000, cout 1, ovf 0. Checks carry ripple across all four nibble boundaries.
- Subtract 0x8000 − 0x0001 → sum 0x7FFF, cout 1, ovf 1. Subtract 0x0003 − 0x0005 → sum 0xFFFE, cout 0, ovf 0.
- Add 0x7FFF + 0x0001 → sum 0x8000, cout 0, ovf 1.
- Pulse start with different operands during RUN and during DONE → ignored; the result is unchanged. Hold start high continuously → back-to-back operations every 6 cycles.
- Drive rst_n low in the 2nd RUN cycle of 0x1111+0x2222:
  - outputs go to 0 immediately, state IDLE, no done;
  - after release, 0x1111+0x2222 → 0x3333.
